// File: rtl/x1_text_fetch_pkg.sv
// rtl/x1_text_fetch_pkg.sv - shared constants, state encoding and attribute row helper for the text fetch
package x1_text_fetch_pkg;

   localparam int ATTR_REV   = 3;
   localparam int ATTR_BLINK = 4;

   localparam logic [2:0] PH_VADDR = 3'd0;
   localparam logic [2:0] PH_VDATA = 3'd2;
   localparam logic [2:0] PH_FDATA = 3'd4;
   localparam logic [2:0] PH_LOAD  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFETCH = 2'd1,
      ST_RUN      = 2'd2
   } state_e;

   // Blink blanks the glyph first so a blinking reverse cell shows a solid block.
   function automatic logic [7:0] cell_row(input logic [7:0] font_row,
                                           input logic [4:0] attr,
                                           input logic       blink_ph);
      logic [7:0] row;
      row = font_row;
      if (attr[ATTR_BLINK] && blink_ph) row = 8'h00;
      if (attr[ATTR_REV]) row = ~row;
      return row;
   endfunction

endpackage

// File: rtl/x1_text_fetch_pix_shift.sv
// rtl/x1_text_fetch_pix_shift.sv - 8-bit load/shift pixel serializer with per-cell colour register
module x1_text_fetch_pix_shift (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       emit,
   input  logic       load,
   input  logic [7:0] row_in,
   input  logic [2:0] color_in,
   output logic       pix_on,
   output logic [2:0] pix_color,
   output logic       pix_de
);

   logic [7:0] shift_q, shift_d;
   logic [2:0] color_q, color_d;
   logic       pix_on_q, pix_on_d;
   logic [2:0] pix_color_q, pix_color_d;
   logic       pix_de_q, pix_de_d;

   always_comb begin
      shift_d     = shift_q;
      color_d     = color_q;
      pix_on_d    = pix_on_q;
      pix_color_d = pix_color_q;
      pix_de_d    = pix_de_q;
      if (ce) begin
         pix_on_d = emit & shift_q[7];
         pix_de_d = emit;
         if (emit) pix_color_d = color_q;
         // The 8th pixel leaves bit 7 on the same edge the next row loads.
         if (load) begin
            shift_d = row_in;
            color_d = color_in;
         end else if (emit) begin
            shift_d = {shift_q[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q     <= 8'h00;
         color_q     <= 3'd0;
         pix_on_q    <= 1'b0;
         pix_color_q <= 3'd0;
         pix_de_q    <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         color_q     <= color_d;
         pix_on_q    <= pix_on_d;
         pix_color_q <= pix_color_d;
         pix_de_q    <= pix_de_d;
      end
   end

   assign pix_on    = pix_on_q;
   assign pix_color = pix_color_q;
   assign pix_de    = pix_de_q;

endmodule

// File: rtl/x1_text_fetch.sv
// rtl/x1_text_fetch.sv - text-plane cell fetch (VRAM, font) and serializer control for one raster line
module x1_text_fetch
   import x1_text_fetch_pkg::*;
#(
   parameter int ADDR_DEPTH = 11,
   parameter int FONT_DEPTH = 11
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CE_PIX,
   input  logic                  LINE_START,
   input  logic [ADDR_DEPTH-1:0] ROW_ADDR,
   input  logic [2:0]            RASTER,
   input  logic [7:0]            COLS,
   input  logic                  BLINK_PH,
   output logic [ADDR_DEPTH-1:0] VRAM_A,
   input  logic [15:0]           VRAM_D,
   output logic [FONT_DEPTH-1:0] FONT_A,
   input  logic [7:0]            FONT_D,
   output logic                  PIX_ON,
   output logic [2:0]            PIX_COLOR,
   output logic                  PIX_DE
);

   state_e                state_q, state_d;
   logic [2:0]            phase_q, phase_d;
   logic [ADDR_DEPTH-1:0] addr_q, addr_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [ADDR_DEPTH-1:0] vram_a_q, vram_a_d;
   logic [FONT_DEPTH-1:0] font_a_q, font_a_d;
   logic [4:0]            attr_q, attr_d;
   logic [7:0]            font_row_q, font_row_d;
   logic                  fetch_en, emit, load;
   logic [7:0]            load_row;
   logic                  unused_vram_hi;

   assign unused_vram_hi = ^VRAM_D[15:13];

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      vram_a_d    = vram_a_q;
      font_a_d    = font_a_q;
      attr_d      = attr_q;
      font_row_d  = font_row_q;
      emit        = 1'b0;
      load        = 1'b0;
      // In RUN the pipeline works on the following cell, which does not exist in the last one.
      fetch_en    = (state_q == ST_PREFETCH) || (remaining_q != 8'd1);
      if (CE_PIX) begin
         if (LINE_START) begin
            addr_d      = ROW_ADDR;
            remaining_d = COLS;
            phase_d     = 3'd0;
            state_d     = (COLS != 8'd0) ? ST_PREFETCH : ST_IDLE;
         end else if (state_q != ST_IDLE) begin
            phase_d = phase_q + 3'd1;
            emit    = (state_q == ST_RUN);
            case (phase_q)
               PH_VADDR: if (fetch_en) begin
                  vram_a_d = addr_q;
                  addr_d   = addr_q + 1'b1;
               end
               PH_VDATA: if (fetch_en) begin
                  font_a_d = {VRAM_D[7:0], RASTER};
                  attr_d   = VRAM_D[12:8];
               end
               PH_FDATA: if (fetch_en) font_row_d = FONT_D;
               PH_LOAD: begin
                  load = fetch_en;
                  if (state_q == ST_PREFETCH) begin
                     state_d = ST_RUN;
                  end else begin
                     remaining_d = remaining_q - 8'd1;
                     if (remaining_q == 8'd1) state_d = ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         phase_q     <= 3'd0;
         addr_q      <= '0;
         remaining_q <= 8'd0;
         vram_a_q    <= '0;
         font_a_q    <= '0;
         attr_q      <= 5'd0;
         font_row_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         vram_a_q    <= vram_a_d;
         font_a_q    <= font_a_d;
         attr_q      <= attr_d;
         font_row_q  <= font_row_d;
      end
   end

   assign VRAM_A   = vram_a_q;
   assign FONT_A   = font_a_q;
   assign load_row = cell_row(font_row_q, attr_q, BLINK_PH);

   x1_text_fetch_pix_shift u_pix_shift (
      .clk       (CLK),
      .rst_n     (RST_N),
      .ce        (CE_PIX),
      .emit      (emit),
      .load      (load),
      .row_in    (load_row),
      .color_in  (attr_q[2:0]),
      .pix_on    (PIX_ON),
      .pix_color (PIX_COLOR),
      .pix_de    (PIX_DE)
   );

endmodule

// File: tb/tb_x1_text_fetch.sv
// tb/tb_x1_text_fetch.sv - directed scoreboard bench for x1_text_fetch with VRAM and font B-port models
module tb_x1_text_fetch;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CE_PIX = 1'b0;
   logic        LINE_START = 1'b0;
   logic [10:0] ROW_ADDR = '0;
   logic [2:0]  RASTER = 3'd3;
   logic [7:0]  COLS = '0;
   logic        BLINK_PH = 1'b0;
   logic [10:0] VRAM_A;
   logic [15:0] VRAM_D = '0;
   logic [10:0] FONT_A;
   logic [7:0]  FONT_D = '0;
   logic        PIX_ON;
   logic [2:0]  PIX_COLOR;
   logic        PIX_DE;

   logic [15:0] vram [0:2047];
   logic [7:0]  font [0:2047];

   int          n_cmp = 0;
   int          n_err = 0;
   int          ce_div = 1;
   int          ce_count, de_count, first_de, last_de;
   logic [10:0] last_va;
   logic [10:0] va_log[$];
   logic [3:0]  exp_q[$];

   x1_text_fetch #(.ADDR_DEPTH(11), .FONT_DEPTH(11)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE_PIX(CE_PIX), .LINE_START(LINE_START),
      .ROW_ADDR(ROW_ADDR), .RASTER(RASTER), .COLS(COLS), .BLINK_PH(BLINK_PH),
      .VRAM_A(VRAM_A), .VRAM_D(VRAM_D), .FONT_A(FONT_A), .FONT_D(FONT_D),
      .PIX_ON(PIX_ON), .PIX_COLOR(PIX_COLOR), .PIX_DE(PIX_DE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      VRAM_D <= vram[VRAM_A];
      FONT_D <= font[FONT_A];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_row(input logic [7:0] row, input logic [2:0] color);
      for (int i = 7; i >= 0; i--) exp_q.push_back({row[i], color});
   endtask

   task automatic tick(input logic ls);
      logic [3:0] e;
      for (int i = 1; i < ce_div; i++) begin
         CE_PIX = 1'b0; LINE_START = 1'b0;
         @(posedge CLK); #1;
      end
      CE_PIX = 1'b1; LINE_START = ls;
      @(posedge CLK); #1;
      CE_PIX = 1'b0; LINE_START = 1'b0;
      ce_count++;
      if (VRAM_A !== last_va) begin
         va_log.push_back(VRAM_A);
         last_va = VRAM_A;
      end
      if (PIX_DE === 1'b1) begin
         de_count++;
         if (first_de < 0) first_de = ce_count;
         last_de = ce_count;
         check("sb_available", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("pixel_ce%0d", ce_count), {PIX_ON, PIX_COLOR}, e);
         end
      end
   endtask

   task automatic start_line(input logic [10:0] row, input logic [7:0] cols);
      ROW_ADDR = row; COLS = cols;
      ce_count = -1; de_count = 0; first_de = -1; last_de = -1;
      va_log.delete(); last_va = VRAM_A;
      tick(1'b1);
   endtask

   task automatic end_line(input string tag, input int n_pix);
      check({tag, "_first_de"}, first_de, 9);
      check({tag, "_de_count"}, de_count, n_pix);
      check({tag, "_consecutive"}, last_de - first_de + 1, de_count);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic push_line2();
      push_row(8'hA5, 3'd7);
      push_row(8'h3C, 3'd3);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         vram[i] = 16'h0000;
         font[i] = 8'h00;
      end
      vram[11'h010] = 16'h0741; font[{8'h41, 3'd3}] = 8'hA5;
      vram[11'h011] = 16'h0342; font[{8'h42, 3'd3}] = 8'h3C;
      vram[11'h020] = 16'h0C50; font[{8'h50, 3'd3}] = 8'hF0;
      vram[11'h021] = 16'h1151; font[{8'h51, 3'd3}] = 8'hFF;
      vram[11'h7FF] = 16'h0160; font[{8'h60, 3'd3}] = 8'h81;
      vram[11'h000] = 16'h0261; font[{8'h61, 3'd3}] = 8'h18;

      // reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pix_de", PIX_DE, 0);
      check("rst_pix_on", PIX_ON, 0);
      check("rst_pix_color", PIX_COLOR, 0);
      check("rst_vram_a", VRAM_A, 0);
      check("rst_font_a", FONT_A, 0);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // basic two-cell line, CE every clock
      push_line2();
      start_line(11'h010, 8'd2);
      repeat (30) tick(1'b0);
      end_line("basic", 16);

      // reverse and blink attributes
      BLINK_PH = 1'b1;
      push_row(8'h0F, 3'd4);
      push_row(8'h00, 3'd1);
      start_line(11'h020, 8'd2);
      repeat (30) tick(1'b0);
      end_line("attr", 16);
      BLINK_PH = 1'b0;

      // address wrap and read suppression past the last cell
      push_row(8'h81, 3'd1);
      push_row(8'h18, 3'd2);
      start_line(11'h7FF, 8'd2);
      repeat (30) tick(1'b0);
      end_line("wrap", 16);
      check("wrap_reads", va_log.size(), 2);
      if (va_log.size() >= 2) begin
         check("wrap_va0", va_log[0], 11'h7FF);
         check("wrap_va1", va_log[1], 11'h000);
      end

      // COLS=0 produces nothing
      start_line(11'h010, 8'd0);
      repeat (20) tick(1'b0);
      check("cols0_reads", va_log.size(), 0);
      check("cols0_de", de_count, 0);

      // CE every third clock gives the same pixels
      ce_div = 3;
      push_line2();
      start_line(11'h010, 8'd2);
      repeat (30) tick(1'b0);
      end_line("ce_div3", 16);
      ce_div = 1;

      // restart at the 4th pixel
      push_line2();
      start_line(11'h010, 8'd2);
      repeat (12) tick(1'b0);
      check("restart_pre_de", de_count, 4);
      exp_q.delete();
      push_line2();
      ce_count = -1; de_count = 0; first_de = -1; last_de = -1;
      tick(1'b1);
      check("restart_de_drop", PIX_DE, 0);
      repeat (30) tick(1'b0);
      end_line("restart", 16);

      // asynchronous reset mid-RUN
      push_line2();
      start_line(11'h010, 8'd2);
      repeat (12) tick(1'b0);
      check("midrun_de_before", PIX_DE, 1);
      #2 RST_N = 1'b0;
      #1;
      check("arst_pix_de", PIX_DE, 0);
      check("arst_pix_on", PIX_ON, 0);
      check("arst_pix_color", PIX_COLOR, 0);
      check("arst_vram_a", VRAM_A, 0);
      check("arst_font_a", FONT_A, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      exp_q.delete();
      va_log.delete(); last_va = VRAM_A; de_count = 0;
      repeat (20) tick(1'b0);
      check("post_rst_reads", va_log.size(), 0);
      check("post_rst_de", de_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
